// File: rtl/commit_unit.sv
// In-order retirement stage: dequeues the ROB head, writes results back to the register file,
// hands stores to the store buffer, and raises flush/redirect on a mispredicted branch.
package commit_pkg;
  localparam int XLEN  = 32;
  localparam int ROB_W = 4;

  typedef struct packed {
    logic [1:0]       itype;
    logic             ready;
    logic [ROB_W-1:0] ROB_number;
    logic [4:0]       dest_reg;
    logic [XLEN-1:0]  result;
    logic             branch_result;
  } ROB_entry_t;
endpackage

module commit_unit #(
  parameter int XLEN         = commit_pkg::XLEN,
  parameter int ROB_W        = commit_pkg::ROB_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  commit_pkg::ROB_entry_t head,
  input  logic                   head_ready,
  input  logic                   rob_empty,
  input  logic                   commit_stall,
  input  logic                   store_ack,
  output logic                   rob_rd_en,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic [ROB_W-1:0]       rf_tag,
  output logic                   store_commit_valid,
  output logic [ROB_W-1:0]       store_commit_rob,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [XLEN-1:0]        redirect_pc,
  output logic [31:0]            commit_count,
  output logic [15:0]            mispredict_count
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {COMMIT, STORE_WAIT, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] flush_cnt;
  logic          retire;
  logic          rd;
  logic          do_wb, do_tag, do_mis, do_store, store_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COMMIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rd         = 1'b0;
    do_wb      = 1'b0;
    do_tag     = 1'b0;
    do_mis     = 1'b0;
    do_store   = 1'b0;
    store_done = 1'b0;
    retire     = !rob_empty && head_ready && !commit_stall;
    unique case (state)
      COMMIT: begin
        if (retire) begin
          unique case (head.itype)
            2'b00: begin
              rd = 1'b1;
              if (head.branch_result) begin
                do_mis    = 1'b1;
                state_nxt = FLUSH;
              end else begin
                do_tag = 1'b1;
              end
            end
            // store is dequeued only once the store buffer acknowledges it
            2'b01: begin
              do_store  = 1'b1;
              state_nxt = STORE_WAIT;
            end
            default: begin
              rd     = 1'b1;
              do_wb  = 1'b1;
              do_tag = 1'b1;
            end
          endcase
        end
      end
      STORE_WAIT: begin
        if (store_ack) begin
          rd         = 1'b1;
          store_done = 1'b1;
          state_nxt  = COMMIT;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_nxt = COMMIT;
      end
      default: state_nxt = COMMIT;
    endcase
  end

  // gate with reset so nothing dequeues while reset is held
  assign rob_rd_en = rd && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we              <= 1'b0;
      rf_waddr           <= '0;
      rf_wdata           <= '0;
      rf_tag             <= '0;
      store_commit_valid <= 1'b0;
      store_commit_rob   <= '0;
      flush              <= 1'b0;
      redirect_valid     <= 1'b0;
      redirect_pc        <= '0;
      commit_count       <= '0;
      mispredict_count   <= '0;
      flush_cnt          <= '0;
    end else begin
      rf_we          <= do_wb && (head.dest_reg != 5'd0);
      flush          <= do_mis;
      redirect_valid <= do_mis;
      if (do_wb && head.dest_reg != 5'd0) begin
        rf_waddr <= head.dest_reg;
        rf_wdata <= head.result;
      end
      if (do_tag) rf_tag <= head.ROB_number;
      if (do_mis) begin
        redirect_pc <= head.result;
        if (mispredict_count != '1) mispredict_count <= mispredict_count + 16'd1;
      end
      if (do_store) begin
        store_commit_valid <= 1'b1;
        store_commit_rob   <= head.ROB_number;
      end else if (store_done) begin
        store_commit_valid <= 1'b0;
      end
      if (rob_rd_en) commit_count <= commit_count + 32'd1;
      flush_cnt <= (state == FLUSH) ? flush_cnt + CW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Randomized and directed bench for commit_unit against a cycle-level behavioural model.
module tb_commit_unit;
  localparam int FC = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  commit_pkg::ROB_entry_t head = '0;
  logic                   head_ready = 1'b0, rob_empty = 1'b1, commit_stall = 1'b0, store_ack = 1'b0;
  logic                   rob_rd_en, rf_we, store_commit_valid, flush, redirect_valid;
  logic [4:0]             rf_waddr;
  logic [31:0]            rf_wdata, redirect_pc, commit_count;
  logic [3:0]             rf_tag, store_commit_rob;
  logic [15:0]            mispredict_count;

  commit_unit #(.XLEN(32), .ROB_W(4), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .head(head), .head_ready(head_ready), .rob_empty(rob_empty),
    .commit_stall(commit_stall), .store_ack(store_ack), .rob_rd_en(rob_rd_en), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_tag(rf_tag),
    .store_commit_valid(store_commit_valid), .store_commit_rob(store_commit_rob), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .commit_count(commit_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a pending-store flag and a count of blocked flush cycles.
  bit          m_store_pending;
  int          m_block;
  bit          m_we, m_flush, m_scv;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_pc, m_cc;
  logic [3:0]  m_tag, m_scr;
  int          m_mc;

  task automatic model_reset();
    m_store_pending = 0; m_block = 0; m_we = 0; m_flush = 0; m_scv = 0;
    m_waddr = '0; m_wdata = '0; m_pc = '0; m_cc = '0; m_tag = '0; m_scr = '0; m_mc = 0;
  endtask

  function automatic bit exp_rd();
    if (!reset) return 0;
    if (m_block > 0) return 0;
    if (m_store_pending) return store_ack;
    return !rob_empty && head_ready && !commit_stall && head.itype != 2'b01;
  endfunction

  task automatic model_step();
    bit r;
    r = exp_rd();
    m_we = 0; m_flush = 0;
    if (r) m_cc = m_cc + 1;
    if (m_block > 0) m_block--;
    else if (m_store_pending) begin
      if (store_ack) begin m_store_pending = 0; m_scv = 0; end
    end else if (!rob_empty && head_ready && !commit_stall) begin
      case (head.itype)
        2'b00: if (head.branch_result) begin
                 m_flush = 1; m_pc = head.result; m_block = FC;
                 if (m_mc < 65535) m_mc++;
               end else m_tag = head.ROB_number;
        2'b01: begin m_store_pending = 1; m_scv = 1; m_scr = head.ROB_number; end
        default: begin
          m_tag = head.ROB_number;
          if (head.dest_reg != 0) begin m_we = 1; m_waddr = head.dest_reg; m_wdata = head.result; end
        end
      endcase
    end
  endtask

  task automatic check_regs();
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_waddr);
    check("rf_wdata", rf_wdata, m_wdata);
    check("rf_tag", rf_tag, m_tag);
    check("store_valid", store_commit_valid, m_scv);
    check("store_rob", store_commit_rob, m_scr);
    check("flush", flush, m_flush);
    check("redirect_valid", redirect_valid, m_flush);
    check("redirect_pc", redirect_pc, m_pc);
    check("commit_count", commit_count, m_cc);
    check("mispredict_count", mispredict_count, 16'(m_mc));
  endtask

  function automatic commit_pkg::ROB_entry_t mk(input logic [1:0] it, input logic [3:0] rob,
                                                input logic [4:0] rd, input logic [31:0] res,
                                                input logic br);
    commit_pkg::ROB_entry_t e;
    e.itype = it; e.ready = 1'b1; e.ROB_number = rob; e.dest_reg = rd; e.result = res;
    e.branch_result = br;
    return e;
  endfunction

  // One cycle: drive at negedge, check dequeue, advance model, check registers after posedge.
  task automatic cycle(input commit_pkg::ROB_entry_t e, input logic rdy, input logic emp,
                       input logic stl, input logic ack);
    @(negedge clk);
    head = e; head.ready = rdy; head_ready = rdy; rob_empty = emp; commit_stall = stl;
    store_ack = ack;
    #1;
    check("rob_rd_en", rob_rd_en, exp_rd());
    model_step();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b0;
    store_ack = 1'b1;
    head_ready = 1'b1; rob_empty = 1'b0;
    #1;
    model_reset();
    check("rst_rd_en", rob_rd_en, 1'b0);
    check_regs();
    @(negedge clk);
    reset = 1'b1; store_ack = 1'b0; rob_empty = 1'b1; head_ready = 1'b0;
  endtask

  commit_pkg::ROB_entry_t idle;

  initial begin
    idle = '0;
    model_reset();
    head = mk(2'b10, 4'd1, 5'd1, 32'h1, 1'b0); head_ready = 1'b1; rob_empty = 1'b0;
    #12;
    check("reset_rd_en", rob_rd_en, 1'b0);
    check_regs();
    @(negedge clk); reset = 1'b1; rob_empty = 1'b1;

    // single ALU retire
    cycle(mk(2'b10, 4'd3, 5'd5, 32'hDEAD_BEEF, 1'b0), 1, 0, 0, 0);
    check("t1_we", rf_we, 1'b1);
    check("t1_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("t1_count", commit_count, 32'd1);
    cycle(idle, 0, 1, 0, 0);

    // back-to-back ALU/load, including dest r0
    cycle(mk(2'b10, 4'd4, 5'd7, 32'h1111, 1'b0), 1, 0, 0, 0);
    cycle(mk(2'b11, 4'd5, 5'd0, 32'h2222, 1'b0), 1, 0, 0, 0);
    cycle(mk(2'b10, 4'd6, 5'd31, 32'h3333, 1'b0), 1, 0, 0, 0);
    cycle(mk(2'b11, 4'd7, 5'd9, 32'h4444, 1'b0), 1, 0, 0, 0);

    // store with ack after three waiting cycles; early ack in request cycle ignored
    cycle(mk(2'b01, 4'd7, 5'd2, 32'h5555, 1'b0), 1, 0, 0, 1);
    cycle(mk(2'b01, 4'd7, 5'd2, 32'h5555, 1'b0), 1, 0, 1, 0);
    cycle(mk(2'b01, 4'd7, 5'd2, 32'h5555, 1'b0), 1, 0, 0, 0);
    cycle(mk(2'b01, 4'd7, 5'd2, 32'h5555, 1'b0), 1, 0, 1, 1);
    cycle(idle, 0, 1, 0, 0);

    // mispredict, then blocked retire attempts
    cycle(mk(2'b00, 4'd8, 5'd0, 32'h0000_0040, 1'b1), 1, 0, 0, 0);
    check("t4_pc", redirect_pc, 32'h40);
    check("t4_mis", mispredict_count, 16'd1);
    for (int i = 0; i < FC + 1; i++) cycle(mk(2'b10, 4'd9, 5'd3, 32'h77, 1'b0), 1, 0, 0, 0);
    cycle(mk(2'b00, 4'd10, 5'd0, 32'h80, 1'b0), 1, 0, 0, 0);

    // stale head while empty, and stalled ready head
    cycle(mk(2'b10, 4'd11, 5'd4, 32'h99, 1'b0), 1, 1, 0, 0);
    cycle(mk(2'b10, 4'd11, 5'd4, 32'h99, 1'b0), 1, 0, 1, 0);
    cycle(mk(2'b00, 4'd12, 5'd0, 32'hA0, 1'b1), 1, 0, 1, 0);

    // reset while waiting on a store, then while flushing
    cycle(mk(2'b01, 4'd13, 5'd0, 32'h0, 1'b0), 1, 0, 0, 0);
    async_reset();
    cycle(mk(2'b10, 4'd14, 5'd6, 32'hABCD, 1'b0), 1, 0, 0, 0);
    cycle(mk(2'b00, 4'd15, 5'd0, 32'h100, 1'b1), 1, 0, 0, 0);
    async_reset();
    cycle(mk(2'b11, 4'd2, 5'd8, 32'h1234, 1'b0), 1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      commit_pkg::ROB_entry_t e;
      e = mk(2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 5'($urandom_range(0, 31)),
             $urandom, 1'($urandom_range(0, 1)));
      cycle(e, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
